// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan test controller.
// Holds the controller state encoding, the default chain length and the
// terminal-count helper used by the bit counter.
package scan_ctrl_pkg;

  localparam int CHAIN_LEN_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } scan_state_t;

  // Last counter value of a shift phase over a chain of chain_len cells.
  function automatic int term_count(input int chain_len);
    return chain_len - 1;
  endfunction

endpackage

// File: rtl/scan_bit_counter.sv
// Bit counter for one scan shift phase.
// Counts shifted bits from 0 up to the terminal count. It is never asked to
// count past the terminal count because the controller leaves the shift state
// there, so it does not wrap.
module scan_bit_counter
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == CNT_W'(term_count(CHAIN_LEN)));

endmodule

// File: rtl/scan_test_controller.sv
// Scan test controller for the 8-bit chain wrapping the 4x4 multiplier.
// Loads one {a,b} vector LSB first, pulses one capture cycle, then unloads
// the product LSB first into a right-shifting capture register.
// Optional feature: define SCAN_CHECK_EN to build the golden-product checker
// (mismatch flag and saturating err_cnt); otherwise both outputs are tied to 0.
//
// Handshakes: a transfer happens on a posedge where valid && ready are both
// high. vec_ready is high only in IDLE; the source must hold vec_valid and the
// vector stable until that edge. res_valid stays high with res_data stable
// until the edge where res_ready is high; res_ready is ignored otherwise.
module scan_test_controller
  import scan_ctrl_pkg::*;
#(
  parameter int A_W       = 4,
  parameter int B_W       = 4,
  parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT  // must equal A_W+B_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic [A_W-1:0]       vec_a,
  input  logic [B_W-1:0]       vec_b,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CHAIN_LEN-1:0] res_data,
  output logic                 busy,
  output logic                 mismatch,
  output logic [7:0]           err_cnt,
  output scan_state_t          dbg_state
);

  localparam int CNT_W = $clog2(CHAIN_LEN);

  scan_state_t          state_q, state_d;
  logic [CHAIN_LEN-1:0] vec_q, vec_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic [CHAIN_LEN-1:0] res_data_q, res_data_d;
  logic                 res_valid_q, res_valid_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 vec_ready_q, vec_ready_d;
  logic                 busy_q, busy_d;
  logic                 cnt_clr, cnt_en, cnt_term;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] shift_word;

  scan_bit_counter #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .term_o (cnt_term)
  );

  // Capture register after this edge's sample: scan_out enters at the top.
  assign shift_word = {scan_out, cap_q[CHAIN_LEN-1:1]};

  // Next state and next values of every registered output. scan_en/scan_in
  // are computed for the state being entered so the chain sees them a full
  // cycle before the edge that uses them.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cap_d       = cap_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    scan_en_d   = 1'b0;
    scan_in_d   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vec_valid) begin
          vec_d     = {vec_a, vec_b};
          cnt_clr   = 1'b1;
          state_d   = S_LOAD;
          scan_en_d = 1'b1;
          scan_in_d = vec_b[0];
        end
      end
      S_LOAD: begin
        if (cnt_term) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_en    = 1'b1;
          scan_en_d = 1'b1;
          scan_in_d = vec_q[cnt + 1'b1];
        end
      end
      S_CAPTURE: begin
        cnt_clr   = 1'b1;
        state_d   = S_UNLOAD;
        scan_en_d = 1'b1;
      end
      S_UNLOAD: begin
        cap_d = shift_word;
        if (cnt_term) begin
          res_data_d  = shift_word;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_en    = 1'b1;
          scan_en_d = 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    vec_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      cap_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= 1'b0;
      vec_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cap_q       <= cap_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      scan_en_q   <= scan_en_d;
      scan_in_q   <= scan_in_d;
      vec_ready_q <= vec_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign vec_ready = vec_ready_q;
  assign scan_en   = scan_en_q;
  assign scan_in   = scan_in_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

`ifdef SCAN_CHECK_EN
  logic [CHAIN_LEN-1:0] golden_q, golden_d;
  logic                 mismatch_q, mismatch_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 chk_accept, chk_result;

  assign chk_accept = (state_q == S_IDLE) && vec_valid;
  assign chk_result = (state_q == S_UNLOAD) && cnt_term;

  // Golden product latched at accept; verdict formed as res_valid rises and
  // cleared when the result is consumed.
  always_comb begin
    golden_d   = golden_q;
    mismatch_d = mismatch_q;
    err_cnt_d  = err_cnt_q;
    if (chk_accept) begin
      golden_d = CHAIN_LEN'(vec_a) * CHAIN_LEN'(vec_b);
    end
    if (chk_result) begin
      mismatch_d = (shift_word != golden_q);
      if ((shift_word != golden_q) && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if ((state_q == S_DONE) && res_ready) begin
      mismatch_d = 1'b0;
    end
  end

  // Checker registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      golden_q   <= '0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      golden_q   <= golden_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;
`else
  assign mismatch = 1'b0;
  assign err_cnt  = 8'h00;
`endif

endmodule
